// File: rtl/max_128b.sv
// max_128b: 4-way unsigned 128-bit maximum with its index. Ties go to the lowest index.
// Build option: define MAX_128B_PIPE_EN for a two-stage pipeline (latency 2); default latency is 1.

module max_128b_pick (
   input  logic [127:0] a,
   input  logic [1:0]   ia,
   input  logic [127:0] b,
   input  logic [1:0]   ib,
   output logic [127:0] w,
   output logic [1:0]   iw
);
   // a always carries the lower index, so only a strictly larger b can take over
   always_comb begin
      w  = a;
      iw = ia;
      if (b > a) begin
         w  = b;
         iw = ib;
      end
   end
endmodule

module max_128b (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [127:0] in0,
   input  logic [127:0] in1,
   input  logic [127:0] in2,
   input  logic [127:0] in3,
   output logic [127:0] out0,
   output logic [1:0]   out1,
   output logic         out_valid
);
`ifdef MAX_128B_PIPE_EN
   localparam int STAGES = 2;
`else
   localparam int STAGES = 1;
`endif

   logic [3:0][127:0] ops;
   logic [1:0][127:0] pv;
   logic [1:0][1:0]   pi;
   logic [1:0][127:0] fv;
   logic [1:0][1:0]   fi;
   logic [127:0]      win;
   logic [1:0]        win_idx;
   logic              fin_load;
   logic [STAGES:1]   vld_pipe;

   assign ops = {in3, in2, in1, in0};

   // pairwise tournament: {in0,in1} and {in2,in3}
   genvar g;
   generate
      for (g = 0; g < 2; g++) begin : g_pair
         max_128b_pick u_pair (
            .a  (ops[2*g]),
            .ia (2'(2*g)),
            .b  (ops[2*g+1]),
            .ib (2'(2*g+1)),
            .w  (pv[g]),
            .iw (pi[g])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[1] <= in_valid;
         for (int i = 2; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
   end

`ifdef MAX_128B_PIPE_EN
   logic [1:0][127:0] s1_val;
   logic [1:0][1:0]   s1_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_val <= '0;
         s1_idx <= '0;
      end else if (in_valid) begin
         s1_val <= pv;
         s1_idx <= pi;
      end
   end

   assign fv       = s1_val;
   assign fi       = s1_idx;
   assign fin_load = vld_pipe[1];
`else
   assign fv       = pv;
   assign fi       = pi;
   assign fin_load = in_valid;
`endif

   // pair 0 enters on port a, so a cross-pair tie keeps the in0/in1 winner
   max_128b_pick u_final (
      .a  (fv[0]),
      .ia (fi[0]),
      .b  (fv[1]),
      .ib (fi[1]),
      .w  (win),
      .iw (win_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out0 <= '0;
         out1 <= '0;
      end else if (fin_load) begin
         out0 <= win;
         out1 <= win_idx;
      end
   end

   assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_max_128b.sv
// Directed and scoreboarded checks for max_128b in whichever configuration is built.
module tb_max_128b;
`ifdef MAX_128B_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid = 1'b0;
   logic [127:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
   logic [127:0] out0;
   logic [1:0]   out1;
   logic         out_valid;

   int n_tests = 0;
   int n_fail  = 0;

   max_128b dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .in0(in0), .in1(in1), .in2(in2), .in3(in3),
      .out0(out0), .out1(out1), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] a, b, c, d;
      logic [127:0] e0;
      logic [1:0]   e1;
   } vec_t;

   localparam logic [127:0] ONES = {128{1'b1}};
   localparam logic [127:0] M    = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
   localparam logic [127:0] X    = 128'hABCD_EF01_2345_6789_0000_0000_0000_0000;

   vec_t vecs[10];
   vec_t strm[3];

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic apply(input logic [127:0] a, b, c, d, input logic v);
      in0 = a; in1 = b; in2 = c; in3 = d; in_valid = v;
   endtask

   // garbage operands whose max would be index 3 / all ones if they leaked
   task automatic idle();
      apply(128'd0, 128'd0, 128'd0, ONES, 1'b0);
   endtask

   function automatic void ref_max(input logic [127:0] a, b, c, d,
                                   output logic [127:0] m, output logic [1:0] ix);
      logic [127:0] o[4];
      o[0] = a; o[1] = b; o[2] = c; o[3] = d;
      m = o[0]; ix = 2'd0;
      for (int i = 1; i < 4; i++)
         if (o[i] > m) begin m = o[i]; ix = 2'(i); end
   endfunction

   function automatic logic [127:0] rv();
      logic [127:0] r;
      r = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 5))
         0: r = '0;
         1: r = ONES;
         2: r = r;
         3: r = 128'($urandom_range(0, 3));
         4: r = 128'd1 << $urandom_range(0, 127);
         default: r = {r[127:64], 64'($urandom_range(0, 2))};
      endcase
      return r;
   endfunction

   initial begin
      vecs[0] = '{128'd5, 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000, 128'd7, 128'd1,
                  128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000, 2'd1};
      vecs[1] = '{ONES, ONES, ONES, ONES, ONES, 2'd0};
      vecs[2] = '{128'd3, 128'd3, 128'd9, 128'd9, 128'd9, 2'd2};
      vecs[3] = '{128'd0, 128'd0, 128'd0, 128'd0, 128'd0, 2'd0};
      vecs[4] = '{M, 128'd1, M, 128'd2, M, 2'd0};
      vecs[5] = '{128'd1, M, 128'd0, M, M, 2'd1};
      vecs[6] = '{{1'b0, {127{1'b1}}}, {1'b0, {127{1'b1}}}, {1'b0, {127{1'b1}}}, 128'd1 << 127,
                  128'd1 << 127, 2'd3};
      vecs[7] = '{X, X, X + 128'd1, X, X + 128'd1, 2'd2};
      vecs[8] = '{128'd0, 128'd0, 128'd0, 128'd1, 128'd1, 2'd3};
      vecs[9] = '{128'd10, 128'd20, 128'd40, 128'd30, 128'd40, 2'd2};
      strm[0] = '{128'd1, 128'd2, 128'd3, 128'd4, 128'd4, 2'd3};
      strm[1] = '{128'd100, 128'd1, 128'd2, 128'd3, 128'd100, 2'd0};
      strm[2] = '{128'd5, 128'd6, 128'd77, 128'd7, 128'd77, 2'd2};

      // asynchronous reset between edges
      #2 rst_n = 1'b0;
      #1;
      check("rst out0", out0, 128'd0);
      check("rst out1", 128'(out1), 128'd0);
      check("rst out_valid", 128'(out_valid), 128'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // single sets, then an idle cycle that must hold the result
      for (int i = 0; i < 10; i++) begin
         @(negedge clk) apply(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, 1'b1);
         @(posedge clk);
         #1 idle();
         repeat (LAT - 1) @(posedge clk);
         #1;
         check($sformatf("vec%0d out0", i), out0, vecs[i].e0);
         check($sformatf("vec%0d out1", i), 128'(out1), 128'(vecs[i].e1));
         check($sformatf("vec%0d out_valid", i), 128'(out_valid), 128'd1);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d idle valid", i), 128'(out_valid), 128'd0);
         check($sformatf("vec%0d hold out0", i), out0, vecs[i].e0);
         check($sformatf("vec%0d hold out1", i), 128'(out1), 128'(vecs[i].e1));
      end

      // back-to-back streaming, then a gap
      for (int cyc = 0; cyc < LAT + 4; cyc++) begin
         int j;
         @(negedge clk);
         if (cyc < 3) apply(strm[cyc].a, strm[cyc].b, strm[cyc].c, strm[cyc].d, 1'b1);
         else idle();
         @(posedge clk);
         #1;
         j = cyc - (LAT - 1);
         if (j >= 0 && j < 3) begin
            check($sformatf("stream%0d out1", j), 128'(out1), 128'(strm[j].e1));
            check($sformatf("stream%0d out0", j), out0, strm[j].e0);
            check($sformatf("stream%0d valid", j), 128'(out_valid), 128'd1);
         end else if (j >= 3) begin
            check("stream gap valid", 128'(out_valid), 128'd0);
            check("stream gap out1", 128'(out1), 128'd2);
            check("stream gap out0", out0, 128'd77);
         end
      end

      // reset while sets are in flight: nothing may emerge afterwards
      @(negedge clk) apply(strm[0].a, strm[0].b, strm[0].c, strm[0].d, 1'b1);
      @(negedge clk) apply(strm[1].a, strm[1].b, strm[1].c, strm[1].d, 1'b1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst out0", out0, 128'd0);
      check("midrst out1", 128'(out1), 128'd0);
      check("midrst valid", 128'(out_valid), 128'd0);
      idle();
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      for (int k = 0; k < LAT + 2; k++) begin
         @(posedge clk);
         #1 check($sformatf("post-rst valid%0d", k), 128'(out_valid), 128'd0);
      end

      // first edge after release captures normally
      @(negedge clk) rst_n = 1'b0;
      #2 rst_n = 1'b1;
      apply(strm[2].a, strm[2].b, strm[2].c, strm[2].d, 1'b1);
      @(posedge clk);
      #1 idle();
      repeat (LAT - 1) @(posedge clk);
      #1;
      check("first-edge out0", out0, 128'd77);
      check("first-edge out1", 128'(out1), 128'd2);
      check("first-edge valid", 128'(out_valid), 128'd1);

      // random sets with random in_valid against a delay-line model
      begin
         logic         dv[2];
         logic [127:0] dm[2];
         logic [1:0]   di[2];
         logic [127:0] hm, m, a, b, c, d;
         logic [1:0]   hi, ix;
         logic         v;
         @(negedge clk) rst_n = 1'b0;
         idle();
         #2 rst_n = 1'b1;
         for (int k = 0; k < 2; k++) begin dv[k] = 1'b0; dm[k] = '0; di[k] = '0; end
         hm = '0; hi = '0;
         for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            v = ($urandom_range(0, 3) != 0);
            a = rv(); b = rv(); c = rv(); d = rv();
            apply(a, b, c, d, v);
            ref_max(a, b, c, d, m, ix);
            for (int k = LAT - 1; k > 0; k--) begin
               dv[k] = dv[k-1]; dm[k] = dm[k-1]; di[k] = di[k-1];
            end
            dv[0] = v; dm[0] = m; di[0] = ix;
            @(posedge clk);
            #1;
            if (dv[LAT-1]) begin hm = dm[LAT-1]; hi = di[LAT-1]; end
            check($sformatf("rand%0d valid", n), 128'(out_valid), 128'(dv[LAT-1]));
            check($sformatf("rand%0d out0", n), out0, hm);
            check($sformatf("rand%0d out1", n), 128'(out1), 128'(hi));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
